// File: rtl/discharge_pkg.sv
// Shared discharge-control types and defaults for the buck phase scheduler and one_cycle_control.
package discharge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FAULT
  } dis_state_e;

  localparam int unsigned DEFAULT_PERIOD = 400;
  localparam int unsigned DEFAULT_MAX_ON = 180;
  localparam int unsigned CALC_LATENCY   = 6;

  // Values with the top bit set are out-of-range results from the calculator.
  function automatic logic [15:0] clamp_on_time(input logic [15:0] on_time,
                                                input logic [15:0] max_on);
    if (on_time[15] || (on_time > max_on)) return max_on;
    return on_time;
  endfunction

  function automatic logic [15:0] ss_ceiling(input logic [15:0] k,
                                             input logic [15:0] step,
                                             input logic [15:0] max_on);
    logic [31:0] prod;
    prod = 32'(k) * 32'(step);
    if (prod >= 32'(max_on)) return max_on;
    return prod[15:0];
  endfunction

endpackage

// File: rtl/buck_phase_timer.sv
// Switching timebase: channel A period counter, half-period-shifted channel B timer and slot owner.
module buck_phase_timer
  import discharge_pkg::*;
#(
  parameter int unsigned PERIOD       = DEFAULT_PERIOD,
  parameter int unsigned PHASE_OFFSET = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_run,
  input  logic        i_count,
  output logic [15:0] o_tmr_a,
  output logic [15:0] o_tmr_b,
  output logic        o_slot_b,
  output logic [15:0] o_slot_tmr
);

  localparam logic [15:0] LP_LAST    = 16'(PERIOD - 1);
  localparam logic [15:0] LP_OFFSET  = 16'(PHASE_OFFSET);
  localparam logic [15:0] LP_B_START = 16'((PERIOD - PHASE_OFFSET) % PERIOD);

  logic [15:0] r_tmr_a;
  logic [15:0] r_tmr_b;

  // B is kept as its own counter so both timers read 0 while the timebase is stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr_a <= '0;
      r_tmr_b <= '0;
    end else if (!i_run) begin
      r_tmr_a <= '0;
      r_tmr_b <= '0;
    end else if (!i_count) begin
      r_tmr_a <= '0;
      r_tmr_b <= LP_B_START;
    end else begin
      r_tmr_a <= (r_tmr_a == LP_LAST) ? '0 : r_tmr_a + 16'd1;
      r_tmr_b <= (r_tmr_b == LP_LAST) ? '0 : r_tmr_b + 16'd1;
    end
  end

  assign o_tmr_a    = r_tmr_a;
  assign o_tmr_b    = r_tmr_b;
  assign o_slot_b   = (r_tmr_a >= LP_OFFSET);
  assign o_slot_tmr = o_slot_b ? (r_tmr_a - LP_OFFSET) : r_tmr_a;

endmodule

// File: rtl/buck_phase_scheduler.sv
// Two-phase buck scheduler sharing one on-time calculator between channels A and B.
// Optional soft-start ramp of the on-time ceiling: define BUCK_SOFT_START_EN.
module buck_phase_scheduler
  import discharge_pkg::*;
#(
  parameter int unsigned PERIOD       = DEFAULT_PERIOD,
  parameter int unsigned PHASE_OFFSET = 200,
  parameter int unsigned CAPTURE_AT   = 8,
  parameter int unsigned MAX_ON       = DEFAULT_MAX_ON,
  parameter int unsigned SS_STEP      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fault,
  input  logic        fault_clear,
  input  logic [15:0] sample_current_a,
  input  logic [15:0] sample_current_b,
  input  logic [15:0] calc_on_time,
  output logic [15:0] calc_timer,
  output logic [15:0] calc_current,
  output logic        gate_a,
  output logic        gate_b,
  output logic        fault_latched,
  output logic        running
);

  localparam logic [15:0] LP_CAPTURE = 16'(CAPTURE_AT);
  localparam logic [15:0] LP_MAX_ON  = 16'(MAX_ON);

  if ((PHASE_OFFSET >= PERIOD) || (CAPTURE_AT <= CALC_LATENCY) ||
      (MAX_ON >= PERIOD) || (SS_STEP == 0)) begin : g_param_check
    $error("buck_phase_scheduler: invalid parameter set");
  end

  dis_state_e  r_state;
  dis_state_e  w_state_nxt;
  logic        w_live;
  logic        w_live_nxt;
  logic [15:0] w_tmr_a;
  logic [15:0] w_tmr_b;
  logic [15:0] w_slot_tmr;
  logic        w_slot_b;
  logic        r_slot_b;
  logic [15:0] r_calc_timer;
  logic [15:0] r_calc_current;
  logic [15:0] r_shadow_a;
  logic [15:0] r_shadow_b;
  logic [15:0] r_active_a;
  logic [15:0] r_active_b;
  logic [15:0] w_apply_a;
  logic [15:0] w_apply_b;
  logic [15:0] w_eff_a;
  logic [15:0] w_eff_b;
  logic [15:0] w_on_clamped;
  logic        w_capture;
  logic        w_gate_a_nxt;
  logic        w_gate_b_nxt;
  logic        r_gate_a;
  logic        r_gate_b;
  logic        r_fault_latched;
  logic        r_running;

  assign w_live     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_live_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);

  buck_phase_timer #(
    .PERIOD       (PERIOD),
    .PHASE_OFFSET (PHASE_OFFSET)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (w_live_nxt),
    .i_count    (w_live),
    .o_tmr_a    (w_tmr_a),
    .o_tmr_b    (w_tmr_b),
    .o_slot_b   (w_slot_b),
    .o_slot_tmr (w_slot_tmr)
  );

`ifdef BUCK_SOFT_START_EN
  logic [15:0] r_k_a;
  logic [15:0] r_k_b;
  logic [15:0] w_ceil_a;
  logic [15:0] w_ceil_b;

  assign w_ceil_a = ss_ceiling(r_k_a, 16'(SS_STEP), LP_MAX_ON);
  assign w_ceil_b = ss_ceiling(r_k_b, 16'(SS_STEP), LP_MAX_ON);

  // k is consumed at each period start, then advanced until the ceiling tops out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_a <= '0;
      r_k_b <= '0;
    end else if (!w_live) begin
      r_k_a <= '0;
      r_k_b <= '0;
    end else begin
      if ((w_tmr_a == '0) && (w_ceil_a != LP_MAX_ON)) r_k_a <= r_k_a + 16'd1;
      if ((w_tmr_b == '0) && (w_ceil_b != LP_MAX_ON)) r_k_b <= r_k_b + 16'd1;
    end
  end

  assign w_apply_a = (r_shadow_a < w_ceil_a) ? r_shadow_a : w_ceil_a;
  assign w_apply_b = (r_shadow_b < w_ceil_b) ? r_shadow_b : w_ceil_b;
`else
  assign w_apply_a = r_shadow_a;
  assign w_apply_b = r_shadow_b;
`endif

  // The gate decision at timer 0 already uses the value being applied this edge.
  assign w_eff_a = (w_tmr_a == '0) ? w_apply_a : r_active_a;
  assign w_eff_b = (w_tmr_b == '0) ? w_apply_b : r_active_b;

  assign w_gate_a_nxt = ((r_state == ST_RUN) && (w_tmr_a < w_eff_a)) ||
                        ((r_state == ST_DRAIN) && r_gate_a && (w_tmr_a < r_active_a));
  assign w_gate_b_nxt = ((r_state == ST_RUN) && (w_tmr_b < w_eff_b)) ||
                        ((r_state == ST_DRAIN) && r_gate_b && (w_tmr_b < r_active_b));

  always_comb begin
    w_state_nxt = r_state;
    if (fault) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE:  if (enable) w_state_nxt = ST_RUN;
        ST_RUN:   if (!enable) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (!w_gate_a_nxt && !w_gate_b_nxt) w_state_nxt = ST_IDLE;
        ST_FAULT: if (fault_clear) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_on_clamped = clamp_on_time(calc_on_time, LP_MAX_ON);
  assign w_capture    = w_live && (r_calc_timer == LP_CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_calc_timer   <= '0;
      r_calc_current <= '0;
      r_slot_b       <= 1'b0;
    end else begin
      r_calc_timer   <= w_slot_tmr;
      r_calc_current <= w_slot_b ? sample_current_b : sample_current_a;
      r_slot_b       <= w_slot_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_a <= '0;
      r_shadow_b <= '0;
      r_active_a <= '0;
      r_active_b <= '0;
    end else if (!w_live) begin
      r_shadow_a <= '0;
      r_shadow_b <= '0;
      r_active_a <= '0;
      r_active_b <= '0;
    end else begin
      if (w_capture && !r_slot_b) r_shadow_a <= w_on_clamped;
      if (w_capture && r_slot_b)  r_shadow_b <= w_on_clamped;
      if (w_tmr_a == '0) r_active_a <= w_apply_a;
      if (w_tmr_b == '0) r_active_b <= w_apply_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_a        <= 1'b0;
      r_gate_b        <= 1'b0;
      r_fault_latched <= 1'b0;
      r_running       <= 1'b0;
    end else begin
      r_gate_a        <= w_gate_a_nxt;
      r_gate_b        <= w_gate_b_nxt;
      r_fault_latched <= (r_state == ST_FAULT);
      r_running       <= w_live;
    end
  end

  assign calc_timer    = r_calc_timer;
  assign calc_current  = r_calc_current;
  assign gate_a        = r_gate_a;
  assign gate_b        = r_gate_b;
  assign fault_latched = r_fault_latched;
  assign running       = r_running;

endmodule

// File: tb/tb_buck_phase_scheduler.sv
// Scoreboard bench for buck_phase_scheduler: expected gate pulses queued by stimulus, checked by a pulse monitor.
module tb_buck_phase_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fault = 1'b0;
  logic        fault_clear = 1'b0;
  logic [15:0] sample_current_a = 16'd40;
  logic [15:0] sample_current_b = 16'd60;
  logic [15:0] calc_on_time = 16'd100;
  logic [15:0] calc_timer;
  logic [15:0] calc_current;
  logic        gate_a;
  logic        gate_b;
  logic        fault_latched;
  logic        running;

  buck_phase_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .fault            (fault),
    .fault_clear      (fault_clear),
    .sample_current_a (sample_current_a),
    .sample_current_b (sample_current_b),
    .calc_on_time     (calc_on_time),
    .calc_timer       (calc_timer),
    .calc_current     (calc_current),
    .gate_a           (gate_a),
    .gate_b           (gate_b),
    .fault_latched    (fault_latched),
    .running          (running)
  );

  typedef struct {
    int unsigned off;
    int unsigned width;
  } pulse_t;

  pulse_t      q_a[$];
  pulse_t      q_b[$];
  int unsigned cyc = 0;
  int unsigned t0 = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, got cycle %0d required end before 30000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle offset %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic expect_pulse(input int ch, input int unsigned off, input int unsigned width);
    pulse_t p;
    p.off   = off;
    p.width = width;
    if (ch == 0) q_a.push_back(p);
    else         q_b.push_back(p);
  endtask

  task automatic at_off(input int unsigned off);
    while (cyc != t0 + off) begin
      if (cyc > t0 + off) begin
        n_checks++;
        n_errors++;
        $display("FAIL schedule: got offset %0d, required %0d", cyc - t0, off);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic score_pulse(input int ch, input int unsigned off, input int unsigned width);
    pulse_t e;
    string  nm;
    nm = (ch == 0) ? "gate_a" : "gate_b";
    if (((ch == 0) && (q_a.size() == 0)) || ((ch == 1) && (q_b.size() == 0))) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_unexpected: got pulse at offset %0d width %0d, required none", nm, off, width);
    end else begin
      e = (ch == 0) ? q_a.pop_front() : q_b.pop_front();
      check({nm, "_offset"}, off, e.off);
      check({nm, "_width"}, width, e.width);
    end
  endtask

  // Pulse monitor: measures each gate pulse in negedge samples.
  initial begin
    logic        prev[2];
    int unsigned rise[2];
    int unsigned wid[2];
    logic        g;
    prev = '{1'b0, 1'b0};
    rise = '{0, 0};
    wid  = '{0, 0};
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        g = (ch == 0) ? gate_a : gate_b;
        if (g) begin
          if (!prev[ch]) begin
            rise[ch] = cyc;
            wid[ch]  = 0;
          end
          wid[ch]++;
        end else if (prev[ch]) begin
          score_pulse(ch, rise[ch] - t0, wid[ch]);
        end
        prev[ch] = g;
      end
    end
  end

`ifdef BUCK_SOFT_START_EN
  int unsigned ss_w[11] = '{20, 40, 60, 80, 100, 120, 140, 160, 180, 180, 180};
`endif

  initial begin
    repeat (3) @(negedge clk);
    check("rst_calc_timer", calc_timer, 0);
    check("rst_calc_current", calc_current, 0);
    check("rst_gate_a", gate_a, 0);
    check("rst_gate_b", gate_b, 0);
    check("rst_fault_latched", fault_latched, 0);
    check("rst_running", running, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

`ifdef BUCK_SOFT_START_EN
    calc_on_time = 16'd180;
    t0 = cyc;
    enable = 1'b1;
    for (int p = 1; p <= 11; p++) begin
      expect_pulse(0, 402 + 400 * (p - 1), ss_w[p - 1]);
      expect_pulse(1, 602 + 400 * (p - 1), ss_w[p - 1]);
    end
    at_off(2);
    check("running_on", running, 1);
    at_off(4791);
    enable = 1'b0;
    at_off(5300);
    check("ss_running_off", running, 0);
`else
    // Normal run: widths from the value captured one period earlier.
    calc_on_time = 16'd100;
    t0 = cyc;
    enable = 1'b1;
    expect_pulse(0, 402, 100);
    expect_pulse(0, 802, 100);
    expect_pulse(0, 1202, 180);
    expect_pulse(0, 1602, 180);
    expect_pulse(0, 2402, 100);
    expect_pulse(1, 602, 100);
    expect_pulse(1, 1002, 100);
    expect_pulse(1, 1402, 180);
    expect_pulse(1, 1802, 180);
    at_off(2);
    check("running_on", running, 1);
    at_off(401);
    check("feed_timer_a_end", calc_timer, 199);
    check("feed_cur_b_end", calc_current, 60);
    at_off(402);
    check("feed_timer_a0", calc_timer, 0);
    check("feed_cur_a0", calc_current, 40);
    at_off(451);
    check("feed_timer_a49", calc_timer, 49);
    check("feed_cur_a49", calc_current, 40);
    at_off(602);
    check("feed_timer_b0", calc_timer, 0);
    check("feed_cur_b0", calc_current, 60);
    at_off(651);
    check("feed_timer_b49", calc_timer, 49);
    check("feed_cur_b49", calc_current, 60);
    at_off(701);
    calc_on_time = 16'd250;
    at_off(1101);
    calc_on_time = 16'hFFF0;
    at_off(1501);
    calc_on_time = 16'd0;
    at_off(1901);
    calc_on_time = 16'd100;
    at_off(2451);
    enable = 1'b0;
    at_off(2520);
    check("drain_running", running, 0);
    check("drain_fault_latched", fault_latched, 0);
    at_off(3000);

    // Fault mid-pulse with enable held high.
    t0 = cyc;
    enable = 1'b1;
    expect_pulse(0, 402, 51);
    at_off(451);
    fault = 1'b1;
    at_off(452);
    check("fault_latched_n", fault_latched, 0);
    check("fault_gate_n", gate_a, 1);
    at_off(453);
    check("fault_gate_n1", gate_a, 0);
    check("fault_latched_n1", fault_latched, 1);
    check("fault_running", running, 0);
    at_off(460);
    fault_clear = 1'b1;
    at_off(461);
    fault_clear = 1'b0;
    at_off(463);
    check("fault_clear_ignored", fault_latched, 1);
    at_off(470);
    fault = 1'b0;
    enable = 1'b0;
    at_off(473);
    check("fault_held", fault_latched, 1);
    at_off(480);
    fault_clear = 1'b1;
    at_off(481);
    fault_clear = 1'b0;
    at_off(483);
    check("fault_cleared", fault_latched, 0);
    check("fault_idle_running", running, 0);

    // Asynchronous reset in the middle of a pulse.
    t0 = cyc;
    enable = 1'b1;
    expect_pulse(0, 402, 50);
    at_off(451);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("reset_async_gate", gate_a, 0);
    at_off(455);
    rst_n = 1'b1;
    at_off(460);
    check("reset_running", running, 0);
`endif

    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/buck_phase_scheduler.md
# buck_phase_scheduler

Shares one `one_cycle_control` on-time calculator between two interleaved buck channels, A and B.
- Generates the 4 us switching timebase for each channel, with B shifted half a period from A.
- Time-multiplexes each channel's current sample and timer into the shared calculator.
- Captures each channel's computed inductor charging time and drives the two buck gates with a guarded on-time.
- Sits between the ADC sample registers, the calculator and the gate-driver outputs in the discharge-control path.

## Interface
Parameters:
- `PERIOD`, 400: switching period in clk cycles (4 us at 100 MHz).
- `PHASE_OFFSET`, 200: channel B lag relative to A, in cycles; must be below `PERIOD`.
- `CAPTURE_AT`, 8: slot-timer value at which the calculator output is captured; must exceed the calculator latency of 6.
- `MAX_ON`, 180: hard on-time ceiling, in cycles.
- `SS_STEP`, 20: soft-start ceiling increment per channel period (used only with the macro in Configuration).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  level; run request.
- `fault`  in  1  level; short/overcurrent indication.
- `fault_clear`  in  1  pulse; acknowledges a latched fault.
- `sample_current_a`  in  16  channel A inductor current.
- `sample_current_b`  in  16  channel B inductor current.
- `calc_on_time`  in  16  calculator `inductor_charging_time` output.
- `calc_timer`  out  16  slot timer fed to the calculator's `timer_buck_4us_0`.
- `calc_current`  out  16  muxed current fed to the calculator's `sample_current`.
- `gate_a`  out  1  channel A switch drive.
- `gate_b`  out  1  channel B switch drive.
- `fault_latched`  out  1  high while in FAULT.
- `running`  out  1  high in RUN or DRAIN.

## Operation
- States:
  - IDLE: timers held at 0, gates low.
  - RUN
  - DRAIN
  - FAULT
- Transitions:
  - IDLE→RUN when `enable`=1.
  - RUN→DRAIN when `enable`=0.
  - DRAIN→IDLE when both gates are low and no pulse is in progress.
  - Any state→FAULT when `fault`=1. Fault takes priority over all other events, including a simultaneous `enable` change.
  - FAULT→IDLE when `fault_clear`=1 and `fault`=0 in the same cycle.
- Timers:
  - `tmr_a` counts 0..PERIOD-1 and wraps to 0.
  - `tmr_b` = (`tmr_a` + PERIOD − PHASE_OFFSET) mod PERIOD. Both equal 0 in IDLE.
- Slot ownership: slot A when `tmr_a` < PHASE_OFFSET, otherwise slot B.
  - Slot timer = `tmr_a` in slot A; `tmr_a` − PHASE_OFFSET in slot B.
  - `calc_timer` = registered slot timer.
  - `calc_current` = registered current of the slot owner. Both are registered in the same cycle so the pair stays aligned.
- Capture: when the registered slot timer equals CAPTURE_AT, the owner's shadow register loads min(`calc_on_time`, MAX_ON).
- Apply: at the channel's own timer = 0, shadow is copied to active.
- Gate: `gate_x` = 1 iff the state is RUN and `tmr_x` < active_x.
  - active_x = 0 produces no pulse.
  - In DRAIN, a pulse that began in RUN continues until `tmr_x` ≥ active_x; no new pulse starts.
- Entry to RUN clears shadow and active to 0, so the first period of each channel produces no pulse.
- FAULT forces both gates low and clears shadow and active.
- Arithmetic: unsigned 16-bit throughout; `calc_on_time` ≥ 0x8000 is treated as MAX_ON.

## Timing
- All outputs are registered.
- Reset values: `calc_timer`=0, `calc_current`=0, `gate_a`=`gate_b`=0, `fault_latched`=0, `running`=0. Internal timers, shadow and active registers also reset to 0.
- `gate_x` rises 1 cycle after `tmr_x`=0 and stays high for exactly active_x cycles.
- `fault` high at edge n gives gates low and `fault_latched`=1 at edge n+1.
- The calculator sees `calc_timer`=0 once per slot, every PHASE_OFFSET cycles (every 200 cycles at defaults).
- Capture lands 8 cycles into the slot and is applied at the channel's next period start, giving ~1 period of latency.
- Reset mid-pulse: gates are low immediately (asynchronous).

## Configuration
- `BUCK_SOFT_START_EN` defined:
  - After entry to RUN, each channel's ceiling is min(MAX_ON, SS_STEP·k), where k counts that channel's completed periods, starting at k=0 for the first period.
  - k saturates once the ceiling reaches MAX_ON.
  - k resets on leaving RUN or DRAIN.
- Undefined: the ceiling is MAX_ON at all times.

## Structure
- Shared package `discharge_pkg`:
  - state enum (IDLE/RUN/DRAIN/FAULT);
  - default constants for period (400 cycles) and maximum on-time (180 cycles), reused by `one_cycle_control`.
- One natural sub-module, `buck_phase_timer`: period counter plus the offset timer and slot-owner flag. The FSM, capture and gate logic stay in the top.

## Test plan
- Reset, then `enable`=1 with `calc_on_time`=100 constant → first gate_a pulse in A's second period, 100 cycles wide; gate_b pulses start 200 cycles after gate_a pulses.
- `calc_on_time`=250 → gates 180 cycles wide; `calc_on_time`=0xFFF0 → 180 cycles; 0 → no pulse.
- Check the calculator feed → `calc_current` switches between A and B samples (A=40, B=60) at each slot boundary; `calc_timer` hits 0 every 200 cycles.
- `enable` low 50 cycles into a 100-cycle gate_a pulse → pulse completes at 100, no further pulses, state reaches IDLE, `running`=0.
- `fault` high mid-pulse, held together with `enable` → gates low next cycle, `fault_latched`=1; `fault_clear` while `fault`=1 is ignored; clear with `fault`=0 → IDLE.
- `BUCK_SOFT_START_EN` with `calc_on_time`=180 → successive channel-A widths 0,20,40,…,180, then constant at 180.
